// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the 7-segment display blocks
// Contents:
//   HEX_PATTERNS     16-entry active-high g..a segment table, index = nibble value
//   calc_ticks()     clock cycles per digit slot for a given clock/refresh/digit count
//   seg_off_level()  7-bit segment level that turns every segment off
//   pin_off_level()  single-pin level that means "off" for a given polarity
package seg7_pkg;

    // Bit 0 = segment a ... bit 6 = segment g. Lower-case b and d avoid clashing with 8 and 0.
    localparam logic [15:0][6:0] HEX_PATTERNS = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    function automatic int calc_ticks(input int clk_hz, input int refresh_hz, input int num_digits);
        return clk_hz / (refresh_hz * num_digits);
    endfunction

    function automatic logic [6:0] seg_off_level(input int active_low);
        return (active_low != 0) ? 7'h7F : 7'h00;
    endfunction

    function automatic logic pin_off_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/seg7_hex_rom.sv
// rtl/seg7_hex_rom.sv - combinational nibble to active-high 7-segment pattern
// Ports:
//   nibble   in  4  hex value 0..F
//   pattern  out 7  active-high segments, bit0=a .. bit6=g
module seg7_hex_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = HEX_PATTERNS[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed multi-digit 7-segment scan driver
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   digits_in    packed hex nibbles, digit i = [4i+3:4i], digit 0 rightmost
//   dp_in        decimal point request per digit
//   blank_in     force digit dark (decimal point still shown)
//   load         capture inputs into the pending register
//   seg, seg_dp  registered segment / decimal point pins (polarity SEG_ACTIVE_LOW)
//   an           registered digit enables, one-hot when active (polarity AN_ACTIVE_LOW)
//   frame_start  one-cycle pulse after the shadow register is updated
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_HZ         = 50000000,
    parameter int REFRESH_HZ     = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int LZS_EN         = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int TICKS  = calc_ticks(CLK_HZ, REFRESH_HZ, NUM_DIGITS);
    localparam int SLOT_W = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(TICKS - 1);
    localparam logic [SLOT_W-1:0]     SLOT_BLNK = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = seg_off_level(SEG_ACTIVE_LOW);
    localparam logic                  DP_OFF    = pin_off_level(SEG_ACTIVE_LOW);
    localparam logic                  AN_OFF_B  = pin_off_level(AN_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_OFF_B}};

    if (TICKS < 2) begin : g_ticks_chk
        $error("seg7_scan_driver: CLK_HZ/(REFRESH_HZ*NUM_DIGITS) must be at least 2");
    end
    if (BLANK_CYCLES >= TICKS) begin : g_blank_chk
        $error("seg7_scan_driver: BLANK_CYCLES must be less than the slot length");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_digits_chk
        $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
    end

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [4*NUM_DIGITS-1:0] shad_digits_q, shad_digits_d;
    logic [NUM_DIGITS-1:0]   shad_dp_q, shad_dp_d;
    logic [NUM_DIGITS-1:0]   shad_blank_q, shad_blank_d;
    logic [6:0]              seg_q, seg_d;
    logic                    seg_dp_q, seg_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_start_q, frame_start_d;

    logic                    boundary;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_dark;
    logic [NUM_DIGITS-1:0]   lzs;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [6:0]              pattern;

    seg7_hex_rom u_hex_rom (
        .nibble  (cur_nib),
        .pattern (pattern)
    );

    // Digit selection and dark-digit decision for the current index.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_dark   = 1'b0;
        lzs        = '0;
        zero_above = 1'b1;
        an_onehot  = '0;
        // Walk from the most significant digit down: a digit is a leading zero only
        // while every digit above it is also zero. Digit 0 always stays visible.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (shad_digits_q[4*i +: 4] == 4'h0);
            lzs[i]     = (LZS_EN != 0) && (i != 0) && zero_above;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib      = shad_digits_q[4*i +: 4];
                cur_dp       = shad_dp_q[i];
                cur_dark     = shad_blank_q[i] || lzs[i];
                an_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        slot_d        = slot_q;
        idx_d         = idx_q;
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_blank_d  = pend_blank_q;
        pend_valid_d  = pend_valid_q;
        shad_digits_d = shad_digits_q;
        shad_dp_d     = shad_dp_q;
        shad_blank_d  = shad_blank_q;
        seg_d         = SEG_OFF;
        seg_dp_d      = DP_OFF;
        an_d          = AN_OFF;
        frame_start_d = 1'b0;

        boundary = (idx_q == IDX_LAST) && (slot_q == SLOT_LAST);

        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end

        // A load on the boundary cycle bypasses pending so it is not delayed a frame.
        if (boundary) begin
            if (load) begin
                shad_digits_d = digits_in;
                shad_dp_d     = dp_in;
                shad_blank_d  = blank_in;
            end else if (pend_valid_q) begin
                shad_digits_d = pend_digits_q;
                shad_dp_d     = pend_dp_q;
                shad_blank_d  = pend_blank_q;
            end
            pend_valid_d  = 1'b0;
            frame_start_d = load || pend_valid_q;
        end else if (load) begin
            pend_digits_d = digits_in;
            pend_dp_d     = dp_in;
            pend_blank_d  = blank_in;
            pend_valid_d  = 1'b1;
        end

        // The first BLANK_CYCLES of each slot keep every anode off to hide ghosting.
        if (slot_q >= SLOT_BLNK) begin
            an_d     = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
            seg_dp_d = cur_dp ? ~DP_OFF : DP_OFF;
            if (!cur_dark) begin
                seg_d = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q        <= '0;
            idx_q         <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            pend_valid_q  <= 1'b0;
            shad_digits_q <= '0;
            shad_dp_q     <= '0;
            shad_blank_q  <= '0;
            seg_q         <= SEG_OFF;
            seg_dp_q      <= DP_OFF;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            pend_valid_q  <= pend_valid_d;
            shad_digits_q <= shad_digits_d;
            shad_dp_q     <= shad_dp_d;
            shad_blank_q  <= shad_blank_d;
            seg_q         <= seg_d;
            seg_dp_q      <= seg_dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign seg_dp      = seg_dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
